// File: rtl/dll_code_tracker_if.sv
// Fabric/DLL-side signal bundle for the DLL code tracker.
// master: fabric + DLL model drive enables, lock and code;
// slave: the tracker drives power-down, update, status.
interface dll_code_tracker_if #(
    parameter int NUM_CH = 2,
    parameter int CODE_W = 8
);
    logic [NUM_CH-1:0]        ENABLE;
    logic                     DRIFT_CLR;
    logic [NUM_CH-1:0]        DLL_LOCK;
    logic [NUM_CH*CODE_W-1:0] DLL_CODE;
    logic [NUM_CH-1:0]        DLL_POWERDOWN_N;
    logic [NUM_CH-1:0]        DLL_CODE_UPDATE;
    logic [NUM_CH*CODE_W-1:0] CODE_OUT;
    logic [NUM_CH-1:0]        CODE_VALID;
    logic [NUM_CH-1:0]        LOCKED;
    logic [NUM_CH-1:0]        DRIFT;
    logic [NUM_CH-1:0]        ERROR;
    logic [NUM_CH*8-1:0]      RELOCK_CNT;

    modport master (
        output ENABLE, DRIFT_CLR, DLL_LOCK, DLL_CODE,
        input  DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_OUT,
        input  CODE_VALID, LOCKED, DRIFT, ERROR, RELOCK_CNT
    );

    modport slave (
        input  ENABLE, DRIFT_CLR, DLL_LOCK, DLL_CODE,
        output DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_OUT,
        output CODE_VALID, LOCKED, DRIFT, ERROR, RELOCK_CNT
    );
endinterface

// File: rtl/dll_code_tracker.sv
// Multi-channel supervisor for DLL hard blocks: power-up, lock
// qualification, periodic code update, drift check, relock.
// Ports: CLK, RESET_N (async active-low), bus (slave modport).
module dll_code_tracker #(
    parameter int NUM_CH        = 2,
    parameter int CODE_W        = 8,
    parameter int PWRUP_WAIT    = 64,
    parameter int LOCK_FILTER   = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int UPDATE_PERIOD = 1024,
    parameter int SETTLE        = 8,
    parameter int DRIFT_THRESH  = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    dll_code_tracker_if.slave bus
);
    localparam int T1   = (PWRUP_WAIT > LOCK_TIMEOUT) ?
                          PWRUP_WAIT : LOCK_TIMEOUT;
    localparam int TMAX = (T1 > UPDATE_PERIOD) ? T1 : UPDATE_PERIOD;
    localparam int CNT_W = $clog2(TMAX) + 1;
    localparam int FLT_W = $clog2(LOCK_FILTER) + 1;

    localparam logic [CNT_W-1:0] PWR_END = CNT_W'(PWRUP_WAIT - 1);
    localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PER_END = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE - 1);
    localparam logic [FLT_W-1:0] FLT_END = FLT_W'(LOCK_FILTER - 1);
    localparam logic [CODE_W:0]  THR     = (CODE_W+1)'(DRIFT_THRESH);

    typedef enum logic [2:0] {
        S_OFF, S_PWRUP, S_LOCKWAIT, S_UPDATE,
        S_WAIT, S_SAMPLE, S_TRACK, S_ERROR
    } state_t;

    logic [NUM_CH-1:0] lock_s1_q;
    logic [NUM_CH-1:0] lock_s2_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_s1_q <= '0;
            lock_s2_q <= '0;
        end else begin
            lock_s1_q <= bus.DLL_LOCK;
            lock_s2_q <= lock_s1_q;
        end
    end

    logic [NUM_CH-1:0]        pdn_o;
    logic [NUM_CH-1:0]        upd_o;
    logic [NUM_CH-1:0]        lck_o;
    logic [NUM_CH-1:0]        err_o;
    logic [NUM_CH-1:0]        vld_o;
    logic [NUM_CH-1:0]        drf_o;
    logic [NUM_CH*CODE_W-1:0] code_o;
    logic [NUM_CH*8-1:0]      rel_o;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
        logic [FLT_W-1:0]  filt_q, filt_d;
        logic [CODE_W-1:0] samp_q, samp_d;
        logic [CODE_W-1:0] ref_q, ref_d;
        logic [CODE_W-1:0] code_q, code_d;
        logic              samp_vld_q, samp_vld_d;
        logic              ref_cap_q, ref_cap_d;
        logic              have_ref_q, have_ref_d;
        logic              valid_q, valid_d;
        logic              drift_q, drift_d;
        logic [7:0]        relock_q, relock_d;
        logic [CODE_W-1:0] code_in;
        logic [CODE_W:0]   diff;
        logic              lock, en, tracking, lost, drift_set;

        assign code_in  = bus.DLL_CODE[i*CODE_W +: CODE_W];
        assign lock     = lock_s2_q[i];
        assign en       = bus.ENABLE[i];
        assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        assign tracking = state_q inside
                          {S_UPDATE, S_WAIT, S_SAMPLE, S_TRACK};
        // Magnitude in CODE_W+1 bits so it never wraps.
        assign diff = (code_in >= ref_q) ?
                      {1'b0, code_in} - {1'b0, ref_q} :
                      {1'b0, ref_q} - {1'b0, code_in};

        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_inc;
            filt_d     = filt_q;
            samp_d     = samp_q;
            samp_vld_d = 1'b0;
            ref_d      = ref_q;
            ref_cap_d  = ref_cap_q;
            have_ref_d = have_ref_q;
            code_d     = code_q;
            valid_d    = 1'b0;
            relock_d   = relock_q;
            drift_set  = 1'b0;
            lost       = 1'b0;

            unique case (state_q)
                S_OFF: begin
                    cnt_d  = '0;
                    filt_d = '0;
                    if (en) state_d = S_PWRUP;
                end
                S_PWRUP: begin
                    if (cnt_q == PWR_END) begin
                        state_d = S_LOCKWAIT;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end
                end
                S_LOCKWAIT: begin
                    filt_d = lock ? filt_q + 1'b1 : '0;
                    // Lock qualification beats a same-cycle timeout.
                    if (lock && filt_q == FLT_END) begin
                        state_d   = S_SAMPLE;
                        ref_cap_d = 1'b1;
                        filt_d    = '0;
                        cnt_d     = '0;
                    end else if (cnt_q == TO_END) begin
                        state_d = S_ERROR;
                    end
                end
                S_UPDATE: begin
                    // cnt counts pulse-to-pulse; pulse cycle is 0.
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == SET_END) state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    samp_d     = code_in;
                    samp_vld_d = 1'b1;
                    if (samp_vld_q && code_in == samp_q) begin
                        samp_vld_d = 1'b0;
                        code_d     = code_in;
                        valid_d    = 1'b1;
                        state_d    = S_TRACK;
                        if (ref_cap_q) begin
                            ref_d      = code_in;
                            ref_cap_d  = 1'b0;
                            have_ref_d = 1'b1;
                        end else if (diff > THR) begin
                            drift_set = 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (cnt_q >= PER_END) begin
                        state_d = S_UPDATE;
                        cnt_d   = '0;
                    end
                end
                S_ERROR: cnt_d = '0;
                default: state_d = S_OFF;
            endcase

            if (tracking) begin
                filt_d = lock ? '0 : filt_q + 1'b1;
                lost   = !lock && (filt_q == FLT_END);
            end

            // Disable and loss of lock both drop to OFF and
            // cancel anything the current cycle would commit.
            if (!en || lost) begin
                state_d    = S_OFF;
                cnt_d      = '0;
                filt_d     = '0;
                samp_vld_d = 1'b0;
                code_d     = code_q;
                valid_d    = 1'b0;
                drift_set  = 1'b0;
                ref_d      = '0;
                ref_cap_d  = 1'b0;
                have_ref_d = 1'b0;
            end
            if (en && lost && !(&relock_q)) begin
                relock_d = relock_q + 8'd1;
            end

            drift_d = drift_set | (drift_q & ~bus.DRIFT_CLR);
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q    <= S_OFF;
                cnt_q      <= '0;
                filt_q     <= '0;
                samp_q     <= '0;
                samp_vld_q <= 1'b0;
                ref_q      <= '0;
                ref_cap_q  <= 1'b0;
                have_ref_q <= 1'b0;
                code_q     <= '0;
                valid_q    <= 1'b0;
                drift_q    <= 1'b0;
                relock_q   <= '0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                filt_q     <= filt_d;
                samp_q     <= samp_d;
                samp_vld_q <= samp_vld_d;
                ref_q      <= ref_d;
                ref_cap_q  <= ref_cap_d;
                have_ref_q <= have_ref_d;
                code_q     <= code_d;
                valid_q    <= valid_d;
                drift_q    <= drift_d;
                relock_q   <= relock_d;
            end
        end

        assign pdn_o[i] = !(state_q inside {S_OFF, S_ERROR});
        assign upd_o[i] = (state_q == S_UPDATE);
        assign lck_o[i] = have_ref_q && tracking;
        assign err_o[i] = (state_q == S_ERROR);
        assign vld_o[i] = valid_q;
        assign drf_o[i] = drift_q;
        assign code_o[i*CODE_W +: CODE_W] = code_q;
        assign rel_o[i*8 +: 8] = relock_q;
    end

    assign bus.DLL_POWERDOWN_N = pdn_o;
    assign bus.DLL_CODE_UPDATE = upd_o;
    assign bus.LOCKED          = lck_o;
    assign bus.ERROR           = err_o;
    assign bus.CODE_VALID      = vld_o;
    assign bus.DRIFT           = drf_o;
    assign bus.CODE_OUT        = code_o;
    assign bus.RELOCK_CNT      = rel_o;
endmodule

// File: tb/tb_dll_code_tracker.sv
// Directed bench for dll_code_tracker: table of drift vectors
// plus hand sequences for lock, relock, timeout and reset.
module tb_dll_code_tracker;
    localparam int NUM_CH = 2;
    localparam int CODE_W = 8;
    localparam int SETTLE = 8;

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLK = ~CLK;

    dll_code_tracker_if #(.NUM_CH(NUM_CH), .CODE_W(CODE_W)) bus();

    dll_code_tracker #(
        .NUM_CH(NUM_CH), .CODE_W(CODE_W), .PWRUP_WAIT(64),
        .LOCK_FILTER(16), .LOCK_TIMEOUT(4096),
        .UPDATE_PERIOD(1024), .SETTLE(SETTLE), .DRIFT_THRESH(4)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    logic [7:0] c0, c1;
    assign bus.DLL_CODE = {c1, c0};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [7:0] code;
        bit         clr;
        logic [7:0] exp_out;
        bit         exp_drift;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic sig(input int w, input int ch);
        case (w)
            0: return bus.CODE_VALID[ch];
            1: return bus.DLL_CODE_UPDATE[ch];
            2: return bus.LOCKED[ch];
            3: return !bus.DLL_POWERDOWN_N[ch];
            4: return bus.DLL_POWERDOWN_N[ch];
            default: return bus.ERROR[ch];
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w, input int ch,
                            input int lim, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sig(w, ch) && n < lim);
        if (!sig(w, ch)) begin
            total++;
            bad++;
            $display("FAIL %s: still low after %0d cycles", nm, n);
        end
    endtask

    int n, t_upd, vcnt;

    initial begin
        tv[0] = '{8'h44, 1'b0, 8'h44, 1'b0};
        tv[1] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
        tv[2] = '{8'h45, 1'b0, 8'h45, 1'b1};
        tv[3] = '{8'h40, 1'b1, 8'h40, 1'b0};
        tv[4] = '{8'h3B, 1'b0, 8'h3B, 1'b1};
        tv[5] = '{8'h41, 1'b1, 8'h41, 1'b0};
        tv[6] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
        tv[7] = '{8'h40, 1'b1, 8'h40, 1'b0};

        bus.ENABLE = '0;
        bus.DRIFT_CLR = 1'b0;
        bus.DLL_LOCK = '0;
        c0 = 8'h00;
        c1 = 8'h00;
        #1 RESET_N = 1'b0;
        step(3);
        chk("rst pdn", 32'(bus.DLL_POWERDOWN_N), 0);
        chk("rst upd", 32'(bus.DLL_CODE_UPDATE), 0);
        chk("rst locked", 32'(bus.LOCKED), 0);
        chk("rst err", 32'(bus.ERROR), 0);
        chk("rst relock", 32'(bus.RELOCK_CNT), 0);
        chk("rst code", 32'(bus.CODE_OUT), 0);
        RESET_N = 1'b1;
        step(2);

        // First lock on ch0
        c0 = 8'h40;
        bus.ENABLE = 2'b01;
        wait_for("pdn0 rise", 4, 0, 5, n);
        chk("pdn0 rise delay", n, 1);
        step(10);
        bus.DLL_LOCK[0] = 1'b1;
        wait_for("first valid", 0, 0, 200, n);
        chk("first code", 32'(bus.CODE_OUT[7:0]), 32'h40);
        chk("first locked", 32'(bus.LOCKED[0]), 1);
        chk("ch1 pdn off", 32'(bus.DLL_POWERDOWN_N[1]), 0);
        step(1);
        chk("valid width", 32'(bus.CODE_VALID[0]), 0);

        // Update pulse timing
        wait_for("upd pulse", 1, 0, 1100, n);
        t_upd = cyc;
        step(1);
        chk("upd width", 32'(bus.DLL_CODE_UPDATE[0]), 0);
        wait_for("valid after upd", 0, 0, 20, n);
        chk("upd to valid", cyc - t_upd, SETTLE + 2);
        wait_for("upd pulse 2", 1, 0, 1100, n);
        chk("upd spacing", cyc - t_upd, 1024);

        // Drift table
        for (int k = 0; k < 8; k++) begin
            c0 = tv[k].code;
            if (tv[k].clr) begin
                bus.DRIFT_CLR = 1'b1;
                step(1);
                bus.DRIFT_CLR = 1'b0;
                chk("drift clr", 32'(bus.DRIFT[0]), 0);
            end
            wait_for("vec valid", 0, 0, 1100, n);
            chk("vec code", 32'(bus.CODE_OUT[7:0]), 32'(tv[k].exp_out));
            chk("vec drift", 32'(bus.DRIFT[0]), 32'(tv[k].exp_drift));
        end

        // DRIFT_CLR in the same cycle as a new drift: set wins
        c0 = 8'h50;
        wait_for("upd for clr", 1, 0, 1100, n);
        step(9);
        bus.DRIFT_CLR = 1'b1;
        step(1);
        bus.DRIFT_CLR = 1'b0;
        chk("clr race valid", 32'(bus.CODE_VALID[0]), 1);
        chk("clr race drift", 32'(bus.DRIFT[0]), 1);
        step(1);
        chk("clr race hold", 32'(bus.DRIFT[0]), 1);
        bus.DRIFT_CLR = 1'b1;
        step(1);
        bus.DRIFT_CLR = 1'b0;
        chk("clr after race", 32'(bus.DRIFT[0]), 0);
        c0 = 8'h40;

        // Loss-of-lock filter
        bus.DLL_LOCK[0] = 1'b0;
        step(15);
        bus.DLL_LOCK[0] = 1'b1;
        step(25);
        chk("glitch15 locked", 32'(bus.LOCKED[0]), 1);
        chk("glitch15 relock", 32'(bus.RELOCK_CNT[7:0]), 0);
        bus.DLL_LOCK[0] = 1'b0;
        wait_for("loss", 3, 0, 30, n);
        bus.DLL_LOCK[0] = 1'b1;
        chk("loss latency", n, 18);
        chk("relock 1", 32'(bus.RELOCK_CNT[7:0]), 1);
        chk("off locked", 32'(bus.LOCKED[0]), 0);
        step(1);
        chk("re-pwrup", 32'(bus.DLL_POWERDOWN_N[0]), 1);
        wait_for("relock", 2, 0, 200, n);

        // Saturation of relock counter
        for (int k = 2; k <= 300; k++) begin
            bus.DLL_LOCK[0] = 1'b0;
            wait_for("sat loss", 3, 0, 30, n);
            bus.DLL_LOCK[0] = 1'b1;
            if (k == 255)
                chk("relock 255", 32'(bus.RELOCK_CNT[7:0]), 255);
            wait_for("sat relock", 2, 0, 200, n);
        end
        chk("relock sat", 32'(bus.RELOCK_CNT[7:0]), 255);
        chk("ch1 relock", 32'(bus.RELOCK_CNT[15:8]), 0);

        // Lock timeout on ch1
        c1 = 8'h80;
        bus.ENABLE[1] = 1'b1;
        wait_for("timeout", 5, 1, 4200, n);
        chk("timeout cycles", n, 4161);
        chk("err pdn", 32'(bus.DLL_POWERDOWN_N[1]), 0);
        bus.DLL_LOCK[1] = 1'b1;
        step(40);
        chk("err sticky", 32'(bus.ERROR[1]), 1);
        bus.ENABLE[1] = 1'b0;
        step(1);
        chk("err clear", 32'(bus.ERROR[1]), 0);
        chk("err off pdn", 32'(bus.DLL_POWERDOWN_N[1]), 0);
        bus.ENABLE[1] = 1'b1;
        step(1);
        chk("err restart", 32'(bus.DLL_POWERDOWN_N[1]), 1);
        wait_for("ch1 lock", 2, 1, 200, n);
        chk("ch1 code", 32'(bus.CODE_OUT[15:8]), 32'h80);

        // Async reset while in WAIT
        wait_for("upd for rst", 1, 0, 1100, n);
        step(3);
        #2 RESET_N = 1'b0;
        #1;
        chk("async pdn", 32'(bus.DLL_POWERDOWN_N), 0);
        chk("async upd", 32'(bus.DLL_CODE_UPDATE), 0);
        chk("async locked", 32'(bus.LOCKED), 0);
        chk("async relock", 32'(bus.RELOCK_CNT), 0);
        chk("async code", 32'(bus.CODE_OUT), 0);
        step(2);
        RESET_N = 1'b1;

        // Unstable code during SAMPLE
        vcnt = 0;
        for (int k = 0; k < 120; k++) begin
            c0 = k[0] ? 8'h11 : 8'h22;
            step(1);
            if (bus.CODE_VALID[0]) vcnt++;
        end
        chk("toggle no valid", vcnt, 0);
        c0 = 8'h33;
        wait_for("stable valid", 0, 0, 5, n);
        chk("stable delay", n, 2);
        chk("stable code", 32'(bus.CODE_OUT[7:0]), 32'h33);
        chk("stable locked", 32'(bus.LOCKED[0]), 1);

        // Disable is not a relock
        bus.ENABLE[0] = 1'b0;
        step(1);
        chk("dis locked", 32'(bus.LOCKED[0]), 0);
        chk("dis pdn", 32'(bus.DLL_POWERDOWN_N[0]), 0);
        step(20);
        chk("dis relock", 32'(bus.RELOCK_CNT[7:0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
